// File: rtl/dmi_pkg.sv
// dmi_pkg: shared definitions for the core-side DMI request handler.
//   - DMI field widths and packed request/response slice positions
//   - request op and response status encodings
//   - handler FSM state type
package dmi_pkg;

  localparam int DMI_ADDR_WIDTH = 7;
  localparam int DMI_DATA_WIDTH = 32;
  localparam int DMI_OP_WIDTH   = 2;
  localparam int DMI_PKT_WIDTH  = DMI_ADDR_WIDTH + DMI_DATA_WIDTH + DMI_OP_WIDTH;

  // Packed {addr, data, op} layout
  localparam int DMI_ADDR_MSB = 40;
  localparam int DMI_ADDR_LSB = 34;
  localparam int DMI_DATA_MSB = 33;
  localparam int DMI_DATA_LSB = 2;
  localparam int DMI_OP_MSB   = 1;
  localparam int DMI_OP_LSB   = 0;

  // Request ops
  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  // Response status (BUSY is never produced: one request is outstanding at most)
  localparam logic [1:0] DMI_RESP_SUCCESS = 2'd0;
  localparam logic [1:0] DMI_RESP_FAILED  = 2'd2;
  localparam logic [1:0] DMI_RESP_BUSY    = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } dmi_state_e;

endpackage

// File: rtl/dmi_req_handler.sv
// dmi_req_handler: core-clock DMI request consumer / response producer.
// Takes one packed {addr,data,op} request at a time from the CDC bridge, runs
// at most one access on the debug-module register bus, and returns a packed
// {addr,data,status} response. A cycle budget covering REQ+WAIT forces a
// FAILED response so a hung bus cannot stall the debugger.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   dmi_req_*                          request valid/ready/data from the CDC
//   dmi_resp_*                         response valid/ready/data to the CDC
//   dm_req_o/we_o/addr_o/wdata_o       register-bus request side
//   dm_gnt_i/rvalid_i/rdata_i/err_i    register-bus grant and completion
//   busy_o                             high whenever the FSM is not IDLE
// All outputs decode from registers only.
module dmi_req_handler
  import dmi_pkg::*;
#(
  parameter int DMI_ADDR_WIDTH = 7,
  parameter int DMI_DATA_WIDTH = 32,
  parameter int DMI_OP_WIDTH   = 2,
  parameter int DATA_WIDTH     = 41,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_CNT_WIDTH   = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [DATA_WIDTH-1:0]     dmi_req_data_i,
  input  logic                      dmi_req_valid_i,
  output logic                      dmi_req_ready_o,
  output logic [DATA_WIDTH-1:0]     dmi_resp_data_o,
  output logic                      dmi_resp_valid_o,
  input  logic                      dmi_resp_ready_i,
  output logic                      dm_req_o,
  output logic                      dm_we_o,
  output logic [DMI_ADDR_WIDTH-1:0] dm_addr_o,
  output logic [DMI_DATA_WIDTH-1:0] dm_wdata_o,
  input  logic                      dm_gnt_i,
  input  logic                      dm_rvalid_i,
  input  logic [DMI_DATA_WIDTH-1:0] dm_rdata_i,
  input  logic                      dm_err_i,
  output logic                      busy_o
);

  localparam int OP_LSB   = 0;
  localparam int DATA_LSB = DMI_OP_WIDTH;
  localparam int ADDR_LSB = DMI_OP_WIDTH + DMI_DATA_WIDTH;
  localparam logic [TO_CNT_WIDTH-1:0] TO_LAST = TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  dmi_state_e                state_q;
  logic [DMI_ADDR_WIDTH-1:0] addr_q;
  logic [DMI_DATA_WIDTH-1:0] wdata_q;
  logic [DMI_OP_WIDTH-1:0]   op_q;
  logic [DMI_DATA_WIDTH-1:0] rdata_q;   // response data field
  logic [DMI_OP_WIDTH-1:0]   rop_q;     // response status field
  logic [TO_CNT_WIDTH-1:0]   cnt_q;

  logic [DMI_ADDR_WIDTH-1:0] req_addr;
  logic [DMI_DATA_WIDTH-1:0] req_data;
  logic [DMI_OP_WIDTH-1:0]   req_op;
  logic                      to_hit;

  assign req_addr = dmi_req_data_i[ADDR_LSB +: DMI_ADDR_WIDTH];
  assign req_data = dmi_req_data_i[DATA_LSB +: DMI_DATA_WIDTH];
  assign req_op   = dmi_req_data_i[OP_LSB   +: DMI_OP_WIDTH];
  assign to_hit   = (cnt_q == TO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      rdata_q <= '0;
      rop_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dmi_req_valid_i) begin
            addr_q  <= req_addr;
            wdata_q <= req_data;
            op_q    <= req_op;
            cnt_q   <= '0;
            rdata_q <= '0;
            if (req_op == DMI_OP_READ || req_op == DMI_OP_WRITE) begin
              state_q <= REQ;
            end else begin
              // NOP succeeds trivially; the reserved op is refused without a bus access
              rop_q   <= (req_op == DMI_OP_NOP) ? DMI_RESP_SUCCESS : DMI_RESP_FAILED;
              state_q <= RESP;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          // a grant on the last budgeted cycle still counts
          if (dm_gnt_i) begin
            state_q <= WAIT;
          end else if (to_hit) begin
            rdata_q <= '0;
            rop_q   <= DMI_RESP_FAILED;
            state_q <= RESP;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (dm_rvalid_i) begin
            rdata_q <= (op_q == DMI_OP_READ) ? dm_rdata_i : '0;
            rop_q   <= dm_err_i ? DMI_RESP_FAILED : DMI_RESP_SUCCESS;
            state_q <= RESP;
          end else if (to_hit) begin
            rdata_q <= '0;
            rop_q   <= DMI_RESP_FAILED;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (dmi_resp_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmi_req_ready_o  = (state_q == IDLE);
  assign dmi_resp_valid_o = (state_q == RESP);
  assign dmi_resp_data_o  = {addr_q, rdata_q, rop_q};
  assign dm_req_o         = (state_q == REQ);
  assign dm_we_o          = (state_q == REQ) && (op_q == DMI_OP_WRITE);
  assign dm_addr_o        = addr_q;
  assign dm_wdata_o       = wdata_q;
  assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_dmi_req_handler.sv
module tb_dmi_req_handler;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [40:0] dmi_req_data_i = '0;
  logic        dmi_req_valid_i = 1'b0;
  logic        dmi_req_ready_o;
  logic [40:0] dmi_resp_data_o;
  logic        dmi_resp_valid_o;
  logic        dmi_resp_ready_i = 1'b1;
  logic        dm_req_o;
  logic        dm_we_o;
  logic [6:0]  dm_addr_o;
  logic [31:0] dm_wdata_o;
  logic        dm_gnt_i = 1'b0;
  logic        dm_rvalid_i = 1'b0;
  logic [31:0] dm_rdata_i = '0;
  logic        dm_err_i = 1'b0;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [40:0] sb[$];

  dmi_req_handler #(
    .DMI_ADDR_WIDTH(7), .DMI_DATA_WIDTH(32), .DMI_OP_WIDTH(2),
    .DATA_WIDTH(41), .TIMEOUT_CYCLES(TO), .TO_CNT_WIDTH(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .dmi_req_data_i(dmi_req_data_i), .dmi_req_valid_i(dmi_req_valid_i),
    .dmi_req_ready_o(dmi_req_ready_o),
    .dmi_resp_data_o(dmi_resp_data_o), .dmi_resp_valid_o(dmi_resp_valid_o),
    .dmi_resp_ready_i(dmi_resp_ready_i),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
    .dm_wdata_o(dm_wdata_o), .dm_gnt_i(dm_gnt_i), .dm_rvalid_i(dm_rvalid_i),
    .dm_rdata_i(dm_rdata_i), .dm_err_i(dm_err_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response handshake must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni && dmi_resp_valid_o && dmi_resp_ready_i) begin
      chk("resp_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) chk("resp_data", 64'(dmi_resp_data_o), 64'(sb.pop_front()));
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic send(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    logic ok;
    ok = 1'b0;
    dmi_req_valid_i = 1'b1;
    dmi_req_data_i  = {a, d, op};
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (dmi_req_ready_o) begin ok = 1'b1; break; end
      @(posedge clk_i); #1;
    end
    chk("req_accept", 64'(ok), 64'd1);
    @(posedge clk_i); #1;
    dmi_req_valid_i = 1'b0;
  endtask

  // Full READ/WRITE: gnt after gdly stall cycles, rvalid the cycle after gnt.
  // Returns at the negedge of the first RESP cycle.
  task automatic run_access(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                            input int gdly, input logic [31:0] rd, input logic er);
    send(a, d, op);
    sb.push_back({a, (op == 2'd1) ? rd : 32'h0, er ? 2'd2 : 2'd0});
    for (int i = 0; i < gdly; i++) begin
      @(negedge clk_i);
      chk("stall_req", 64'(dm_req_o), 64'd1);
      chk("stall_wdata", 64'(dm_wdata_o), 64'(d));
      @(posedge clk_i); #1;
    end
    dm_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("gnt_req", 64'(dm_req_o), 64'd1);
    chk("gnt_we", 64'(dm_we_o), 64'(op == 2'd2));
    chk("gnt_addr", 64'(dm_addr_o), 64'(a));
    chk("gnt_wdata", 64'(dm_wdata_o), 64'(d));
    @(posedge clk_i); #1;
    dm_gnt_i = 1'b0;
    dm_rvalid_i = 1'b1; dm_rdata_i = rd; dm_err_i = er;
    @(negedge clk_i);
    chk("wait_req_drop", 64'(dm_req_o), 64'd0);
    chk("wait_busy", 64'(busy_o), 64'd1);
    @(posedge clk_i); #1;
    dm_rvalid_i = 1'b0; dm_rdata_i = '0; dm_err_i = 1'b0;
    @(negedge clk_i);
    chk("resp_valid", 64'(dmi_resp_valid_o), 64'd1);
  endtask

  initial begin
    int hi;
    logic seen;
    logic [40:0] bp_exp;

    // Reset state
    #2;
    chk("rst_req_ready", 64'(dmi_req_ready_o), 64'd1);
    chk("rst_resp_valid", 64'(dmi_resp_valid_o), 64'd0);
    chk("rst_resp_data", 64'(dmi_resp_data_o), 64'd0);
    chk("rst_dm_req", 64'(dm_req_o), 64'd0);
    chk("rst_dm_we", 64'(dm_we_o), 64'd0);
    chk("rst_dm_addr", 64'(dm_addr_o), 64'd0);
    chk("rst_dm_wdata", 64'(dm_wdata_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // READ: accept, gnt immediately, rvalid next cycle -> RESP at cycle 3
    run_access(7'h11, 32'h0, 2'd1, 0, 32'hDEADBEEF, 1'b0);
    @(posedge clk_i); #1;

    // WRITE with 3 stall cycles and bus error
    run_access(7'h10, 32'h80000001, 2'd2, 3, 32'h12345678, 1'b1);
    @(posedge clk_i); #1;

    // NOP: response on cycle 1, no bus activity
    send(7'h05, 32'hFFFFFFFF, 2'd0);
    sb.push_back({7'h05, 32'h0, 2'd0});
    @(negedge clk_i);
    chk("nop_resp_valid", 64'(dmi_resp_valid_o), 64'd1);
    chk("nop_dm_req", 64'(dm_req_o), 64'd0);
    @(posedge clk_i); #1;

    // Reserved op -> FAILED
    send(7'h7F, 32'hA5A5A5A5, 2'd3);
    sb.push_back({7'h7F, 32'h0, 2'd2});
    @(negedge clk_i);
    chk("rsv_resp_valid", 64'(dmi_resp_valid_o), 64'd1);
    chk("rsv_dm_req", 64'(dm_req_o), 64'd0);
    @(posedge clk_i); #1;

    // Timeout: gnt never arrives
    send(7'h22, 32'h0, 2'd1);
    sb.push_back({7'h22, 32'h0, 2'd2});
    hi = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (dmi_resp_valid_o) begin seen = 1'b1; break; end
      if (dm_req_o) hi++;
    end
    chk("to_resp_seen", 64'(seen), 64'd1);
    chk("to_req_cycles", 64'(hi), 64'(TO));
    chk("to_dm_req_low", 64'(dm_req_o), 64'd0);
    @(posedge clk_i); #1;
    // Stray rvalid after the timeout must be ignored
    dm_rvalid_i = 1'b1; dm_rdata_i = 32'hBAD0BAD0;
    @(negedge clk_i);
    chk("stray_no_resp", 64'(dmi_resp_valid_o), 64'd0);
    chk("stray_idle", 64'(busy_o), 64'd0);
    @(posedge clk_i); #1;
    dm_rvalid_i = 1'b0; dm_rdata_i = '0;
    run_access(7'h23, 32'h0, 2'd1, 0, 32'hCAFEF00D, 1'b0);
    @(posedge clk_i); #1;

    // Backpressure on the response
    dmi_resp_ready_i = 1'b0;
    bp_exp = {7'h33, 32'h0BADC0DE, 2'd0};
    run_access(7'h33, 32'h0, 2'd1, 1, 32'h0BADC0DE, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("bp_valid", 64'(dmi_resp_valid_o), 64'd1);
      chk("bp_data", 64'(dmi_resp_data_o), 64'(bp_exp));
      chk("bp_req_ready", 64'(dmi_req_ready_o), 64'd0);
    end
    @(posedge clk_i); #1;
    dmi_resp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_hs_req_ready", 64'(dmi_req_ready_o), 64'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("bp_after_req_ready", 64'(dmi_req_ready_o), 64'd1);
    @(posedge clk_i); #1;

    // Async reset while in WAIT: aborted request yields no response
    send(7'h44, 32'h0, 2'd1);
    dm_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    dm_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("ar_in_wait", 64'(busy_o & ~dm_req_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("ar_dm_req", 64'(dm_req_o), 64'd0);
    chk("ar_resp_valid", 64'(dmi_resp_valid_o), 64'd0);
    chk("ar_req_ready", 64'(dmi_req_ready_o), 64'd1);
    chk("ar_busy", 64'(busy_o), 64'd0);
    @(posedge clk_i); #1;
    dm_rvalid_i = 1'b1; dm_rdata_i = 32'h55555555;
    @(posedge clk_i); #1;
    dm_rvalid_i = 1'b0; dm_rdata_i = '0;
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("ar_no_resp", 64'(dmi_resp_valid_o), 64'd0);
    chk("ar_idle", 64'(busy_o), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
